interrupt_arbiter: RTL and testbench

Collects up to NUM_IRQ peripheral interrupt lines, latches them as pending, masks and prioritises them, and presents one request at a time to interrupt_controller. It drives the controller's interrupt_signal input, reports the granted source ID for the ISR, and uses the controller's ISR_en / ret_ISR outputs as a grant/return handshake. Nested interrupts are not supported: one ISR is in service at a time.

---
 rtl/int_arb_pkg.sv | 13 +
 rtl/int_arb_pick.sv | 31 +++
 rtl/interrupt_arbiter.sv | 128 ++++++++++++
 tb/tb_interrupt_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/int_arb_pkg.sv
// Shared types and defaults for the interrupt arbiter.
// State encoding of the request/service handshake FSM.
package int_arb_pkg;

    localparam int NUM_IRQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/int_arb_pick.sv
// Combinational winner search over the eligible vector, starting at start_i and wrapping.
// vld_o is low when nothing is eligible; id_o is then 0.
module int_arb_pick #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] eligible_i,
    input  logic [ID_W-1:0]    start_i,
    output logic               vld_o,
    output logic [ID_W-1:0]    id_o
);

    logic found;
    int   j;

    always_comb begin
        found = 1'b0;
        id_o  = '0;
        j     = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            j = int'(start_i) + i;
            if (j >= NUM_IRQ) j = j - NUM_IRQ;
            if (!found && eligible_i[j]) begin
                found = 1'b1;
                id_o  = ID_W'(j);
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Latches irq edges as pending, masks/prioritises them and runs a one-at-a-time req/ack/ret handshake.
// Fixed lowest-index priority by default; INT_ARB_ROUND_ROBIN_EN selects round-robin from the last grant.
module interrupt_arbiter
    import int_arb_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [NUM_IRQ-1:0] cfg_mask,
    input  logic               isr_ack,
    input  logic               isr_ret,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic               irq_busy,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] irq_src_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    state_t             state_q;
    logic               irq_req_q, irq_busy_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [ID_W-1:0]    start_idx;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;
    logic               ack_fire;

    assign rise     = irq_src & ~irq_src_q;
    assign eligible = pending_q & mask_q;
    assign ack_fire = (state_q == REQ) && isr_ack;

    // A new edge on the same cycle as the ack clear must survive, so set is OR-ed in last.
    always_comb begin
        clr = '0;
        if (ack_fire) clr[irq_id_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            irq_src_q <= '0;
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            irq_src_q <= irq_src;
            pending_q <= pending_d;
            if (cfg_we) mask_q <= cfg_mask;
        end
    end

`ifdef INT_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q <= '0;
        end else if (ack_fire) begin
            ptr_q <= irq_id_q;
        end
    end

    assign start_idx = (ptr_q == ID_W'(NUM_IRQ - 1)) ? '0 : ptr_q + ID_W'(1);
`else
    assign start_idx = '0;
`endif

    int_arb_pick #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_pick (
        .eligible_i (eligible),
        .start_i    (start_idx),
        .vld_o      (win_vld),
        .id_o       (win_id)
    );

    // Once in REQ the grant is committed: mask or source changes do not revisit the choice.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            irq_req_q  <= 1'b0;
            irq_busy_q <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        irq_id_q  <= win_id;
                        irq_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (isr_ack) begin
                        irq_req_q  <= 1'b0;
                        irq_busy_q <= 1'b1;
                        state_q    <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (isr_ret) begin
                        irq_busy_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    irq_req_q  <= 1'b0;
                    irq_busy_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign irq_req  = irq_req_q;
    assign irq_busy = irq_busy_q;
    assign irq_id   = irq_id_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: handshake, masking, priority, re-pend and reset cases.
module tb_interrupt_arbiter;

    logic       clk;
    logic       nrst;
    logic [3:0] irq_src;
    logic       cfg_we;
    logic [3:0] cfg_mask;
    logic       isr_ack;
    logic       isr_ret;
    logic       irq_req;
    logic [1:0] irq_id;
    logic       irq_busy;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    logic [1:0] first_id, second_id;

    interrupt_arbiter #(.NUM_IRQ(4)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .irq_src  (irq_src),
        .cfg_we   (cfg_we),
        .cfg_mask (cfg_mask),
        .isr_ack  (isr_ack),
        .isr_ret  (isr_ret),
        .irq_req  (irq_req),
        .irq_id   (irq_id),
        .irq_busy (irq_busy),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        cfg_we   = 1'b1;
        cfg_mask = m;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic pulse(input logic [3:0] s);
        irq_src = s;
        tick();
        irq_src = 4'b0000;
    endtask

    initial begin
`ifdef INT_ARB_ROUND_ROBIN_EN
        first_id  = 2'd3;
        second_id = 2'd0;
`else
        first_id  = 2'd0;
        second_id = 2'd3;
`endif
        nrst = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_mask = '0;
        isr_ack = 1'b0; isr_ret = 1'b0;
        tick(); tick();
        chk("rst_req", irq_req, 0);
        chk("rst_busy", irq_busy, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_pend", pending, 0);
        nrst = 1'b1;
        tick();

        // Basic request/ack/return on source 2
        write_mask(4'b1111);
        pulse(4'b0100);
        chk("s1_pend", pending, 4'b0100);
        chk("s1_req_early", irq_req, 0);
        tick();
        chk("s1_req", irq_req, 1);
        chk("s1_id", irq_id, 2);
        isr_ack = 1'b1; tick(); isr_ack = 1'b0;
        chk("s1_ack_req", irq_req, 0);
        chk("s1_ack_busy", irq_busy, 1);
        chk("s1_ack_pend", pending, 0);
        tick();
        chk("s1_hold_busy", irq_busy, 1);
        isr_ret = 1'b1; tick(); isr_ret = 1'b0;
        chk("s1_ret_busy", irq_busy, 0);
        tick();
        chk("s1_no_req", irq_req, 0);

        // Masked pending, then enabled by a mask write
        write_mask(4'b0000);
        pulse(4'b0010);
        chk("s2_pend", pending, 4'b0010);
        tick(); tick();
        chk("s2_masked_req", irq_req, 0);
        write_mask(4'b0010);
        chk("s2_wr_req", irq_req, 0);
        tick();
        chk("s2_req", irq_req, 1);
        chk("s2_id", irq_id, 1);
        isr_ack = 1'b1; tick(); isr_ack = 1'b0;
        isr_ret = 1'b1; tick(); isr_ret = 1'b0;
        chk("s2_done", irq_busy, 0);

        // Sources 0 and 3 together from a fresh pointer
        do_reset();
        write_mask(4'b1111);
        pulse(4'b1001);
        chk("s3_pend", pending, 4'b1001);
        tick();
        chk("s3_req1", irq_req, 1);
        chk("s3_id1", irq_id, first_id);
        isr_ack = 1'b1; tick(); isr_ack = 1'b0;
        chk("s3_pend_after1", pending, 4'b1001 & ~(4'b0001 << first_id));
        isr_ret = 1'b1; tick(); isr_ret = 1'b0;
        chk("s3_gap_req", irq_req, 0);
        tick();
        chk("s3_req2", irq_req, 1);
        chk("s3_id2", irq_id, second_id);
        isr_ack = 1'b1; tick(); isr_ack = 1'b0;
        isr_ret = 1'b1; tick(); isr_ret = 1'b0;
        chk("s3_pend_end", pending, 0);

        // Source 1 re-pulses on its own ack edge
        tick();
        pulse(4'b0010);
        tick();
        chk("s4_req", irq_req, 1);
        chk("s4_id", irq_id, 1);
        isr_ack = 1'b1; irq_src = 4'b0010;
        tick();
        isr_ack = 1'b0; irq_src = 4'b0000;
        chk("s4_set_wins", pending, 4'b0010);
        chk("s4_busy", irq_busy, 1);
        tick();
        isr_ret = 1'b1; tick(); isr_ret = 1'b0;
        chk("s4_ret_busy", irq_busy, 0);
        chk("s4_idle_gap", irq_req, 0);
        tick();
        chk("s4_req_again", irq_req, 1);
        chk("s4_id_again", irq_id, 1);
        isr_ack = 1'b1; tick(); isr_ack = 1'b0;
        isr_ret = 1'b1; tick(); isr_ret = 1'b0;

        // Stray handshakes are ignored
        isr_ret = 1'b1; tick(); isr_ret = 1'b0;
        chk("s5_ret_idle_req", irq_req, 0);
        chk("s5_ret_idle_busy", irq_busy, 0);
        pulse(4'b0001);
        tick();
        chk("s5_req", irq_req, 1);
        isr_ack = 1'b1; tick();
        chk("s5_busy", irq_busy, 1);
        tick(); isr_ack = 1'b0;
        chk("s5_ack_serv_busy", irq_busy, 1);
        chk("s5_ack_serv_req", irq_req, 0);
        chk("s5_ack_serv_id", irq_id, 0);

        // Async reset mid-service with pending bits outstanding
        pulse(4'b1010);
        chk("s6_pend", pending, 4'b1010);
        chk("s6_busy", irq_busy, 1);
        #2 nrst = 1'b0;
        #1;
        chk("s6_rst_req", irq_req, 0);
        chk("s6_rst_busy", irq_busy, 0);
        chk("s6_rst_id", irq_id, 0);
        chk("s6_rst_pend", pending, 0);
        tick();
        nrst = 1'b1;
        tick(); tick(); tick();
        chk("s6_no_replay", irq_req, 0);
        pulse(4'b0100);
        tick(); tick();
        chk("s6_mask_reset", irq_req, 0);
        chk("s6_pend_masked", pending, 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
